// File: rtl/bitonic_sort_iter.sv
// Iterative bitonic sorter: one compare-exchange stage per clock over a single
// working vector, with ready/valid handshakes on input and output.
module bitonic_sort_iter #(
  parameter int N_ELEMS = 4,
  parameter int DATA_W  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_ELEMS*DATA_W-1:0]   data_in,
  input  logic                        descending,
  input  logic                        valid,
  output logic                        ready,
  output logic [N_ELEMS*DATA_W-1:0]   data_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        done
);

  localparam int L      = $clog2(N_ELEMS);
  localparam int STAGES = L * (L + 1) / 2;
  localparam int CNT_W  = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int VEC_W  = N_ELEMS * DATA_W;

  // Map a flat stage index onto the (log2 k, log2 j) pair of the bitonic schedule.
  function automatic int stage_k_log(input int s);
    int idx;
    int res;
    idx = 0;
    res = 1;
    for (int kl = 1; kl <= L; kl++) begin
      for (int jl = kl - 1; jl >= 0; jl--) begin
        if (idx == s) res = kl;
        idx = idx + 1;
      end
    end
    return res;
  endfunction

  function automatic int stage_j_log(input int s);
    int idx;
    int res;
    idx = 0;
    res = 0;
    for (int kl = 1; kl <= L; kl++) begin
      for (int jl = kl - 1; jl >= 0; jl--) begin
        if (idx == s) res = jl;
        idx = idx + 1;
      end
    end
    return res;
  endfunction

  typedef enum logic [1:0] {IDLE, SORT, OUT} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   stage_reg;
  logic [VEC_W-1:0]   work_reg;
  logic               desc_reg;
  logic               done_reg;
  logic               last_stage;
  logic [VEC_W-1:0]   stage_vec [STAGES];

  assign last_stage = (stage_reg == CNT_W'(STAGES - 1));
  assign data_out   = work_reg;
  assign done       = done_reg;

  // Every stage network is built in parallel; the stage counter picks one per cycle.
  genvar gs, gi;
  generate
    for (gs = 0; gs < STAGES; gs++) begin : g_stage
      localparam int K = 1 << stage_k_log(gs);
      localparam int J = 1 << stage_j_log(gs);
      for (gi = 0; gi < N_ELEMS; gi++) begin : g_elem
        localparam int  LI  = gi ^ J;
        localparam bit  ASC = ((gi & K) == 0);
        if (LI > gi) begin : g_pair
          logic [DATA_W-1:0] key_a, key_b;
          logic              swap;
          assign key_a = work_reg[gi*DATA_W +: DATA_W];
          assign key_b = work_reg[LI*DATA_W +: DATA_W];
          assign swap  = (ASC ^ desc_reg) ? (key_a > key_b) : (key_a < key_b);
          assign stage_vec[gs][gi*DATA_W +: DATA_W] = swap ? key_b : key_a;
          assign stage_vec[gs][LI*DATA_W +: DATA_W] = swap ? key_a : key_b;
        end
      end
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (valid) state_next = SORT;
      end
      SORT: begin
        if (last_stage) state_next = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      stage_reg <= '0;
      work_reg  <= '0;
      desc_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= (state_reg == SORT) && last_stage;
      case (state_reg)
        IDLE: begin
          if (valid) begin
            work_reg  <= data_in;
            desc_reg  <= descending;
            stage_reg <= '0;
          end
        end
        SORT: begin
          work_reg  <= stage_vec[stage_reg];
          stage_reg <= stage_reg + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
